// File: rtl/rat_pkg.sv
// Shared types for the RAT MCU flag unit: branch-condition codes, ack-state FSM encoding
// and the C/Z flag pair.
package rat_pkg;

  localparam int unsigned BR_W = 3;

  typedef enum logic [BR_W-1:0] {
    BR_ALWAYS = 3'd0,
    BR_CS     = 3'd1,
    BR_CC     = 3'd2,
    BR_EQ     = 3'd3,
    BR_NE     = 3'd4
  } br_cond_t;

  typedef enum logic {
    ACK_IDLE  = 1'b0,
    ACK_ACKED = 1'b1
  } ack_state_t;

  typedef struct packed {
    logic c;
    logic z;
  } flags_t;

  // Codes 101-111 fall through to "never taken".
  function automatic logic br_eval(logic [BR_W-1:0] cond, flags_t f);
    case (cond)
      BR_ALWAYS: return 1'b1;
      BR_CS:     return f.c;
      BR_CC:     return ~f.c;
      BR_EQ:     return f.z;
      BR_NE:     return ~f.z;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rat_flag_unit_if.sv
// Flag/branch interface between the ALU + control unit (master) and the flag unit (slave).
interface rat_flag_unit_if;
  import rat_pkg::*;

  logic            c_in;
  logic            z_in;
  logic            flg_c_ld;
  logic            flg_c_set;
  logic            flg_c_clr;
  logic            flg_z_ld;
  logic            flg_shad_ld;
  logic            flg_ld_sel;
  logic            i_set;
  logic            i_clr;
  logic            intr;
  logic            int_ack;
  logic [BR_W-1:0] br_cond;

  logic            c_flag;
  logic            z_flag;
  logic            i_flag;
  logic            int_pend;
  logic            br_take;

  modport master (
    output c_in, z_in, flg_c_ld, flg_c_set, flg_c_clr, flg_z_ld, flg_shad_ld,
           flg_ld_sel, i_set, i_clr, intr, int_ack, br_cond,
    input  c_flag, z_flag, i_flag, int_pend, br_take
  );

  modport slave (
    input  c_in, z_in, flg_c_ld, flg_c_set, flg_c_clr, flg_z_ld, flg_shad_ld,
           flg_ld_sel, i_set, i_clr, intr, int_ack, br_cond,
    output c_flag, z_flag, i_flag, int_pend, br_take
  );

endinterface

// File: rtl/rat_intr_sync.sv
// External interrupt request conditioning: optional 2-FF synchronizer followed by a
// rising-edge detector. rise_c is a one-cycle pulse per 0->1 transition.
module rat_intr_sync #(
  parameter bit SYNC_INTR = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic intr,
  output logic rise_c
);

  generate
    if (SYNC_INTR) begin : g_sync
      // sh[1:0] is the synchronizer, sh[2] the edge-detect history.
      logic [2:0] sh_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sh_q <= '0;
        else        sh_q <= {sh_q[1:0], intr};
      end

      assign rise_c = sh_q[1] & ~sh_q[2];
    end else begin : g_bypass
      logic prev_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= 1'b0;
        else        prev_q <= intr;
      end

      assign rise_c = intr & ~prev_q;
    end
  endgenerate

endmodule

// File: rtl/rat_flag_unit.sv
// RAT MCU flag unit: C/Z flags with shadow save/restore, interrupt enable, latched
// interrupt request and branch-condition evaluation.
module rat_flag_unit
  import rat_pkg::*;
#(
  parameter bit SYNC_INTR = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  rat_flag_unit_if.slave fl
);

  flags_t     flg_q, flg_d;
  flags_t     shad_q, shad_d;
  logic       i_q, i_d;
  logic       pend_q, pend_d;
  ack_state_t ack_q, ack_d;
  logic       rise_c;
  logic       restore_c;

  rat_intr_sync #(.SYNC_INTR(SYNC_INTR)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .intr   (fl.intr),
    .rise_c (rise_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flg_q  <= '0;
      shad_q <= '0;
      i_q    <= 1'b0;
      pend_q <= 1'b0;
      ack_q  <= ACK_IDLE;
    end else begin
      flg_q  <= flg_d;
      shad_q <= shad_d;
      i_q    <= i_d;
      pend_q <= pend_d;
      ack_q  <= ack_d;
    end
  end

  // Next-state: every update reads pre-edge values, so save+restore in one cycle swaps.
  always_comb begin
    ack_d     = ack_q;
    flg_d     = flg_q;
    shad_d    = shad_q;
    i_d       = i_q;
    pend_d    = pend_q;
    restore_c = fl.flg_ld_sel & (fl.flg_c_ld | fl.flg_z_ld);

    case (ack_q)
      ACK_IDLE:  if (fl.int_ack) ack_d = ACK_ACKED;
      ACK_ACKED: if (restore_c)  ack_d = ACK_IDLE;
      default:   ack_d = ACK_IDLE;
    endcase

    // A nested ack must not overwrite the context saved by the first one.
    if (fl.flg_shad_ld || (fl.int_ack && (ack_q == ACK_IDLE))) shad_d = flg_q;

    if (fl.flg_c_clr)      flg_d.c = 1'b0;
    else if (fl.flg_c_set) flg_d.c = 1'b1;
    else if (fl.int_ack)   flg_d.c = flg_q.c;
    else if (fl.flg_c_ld)  flg_d.c = fl.flg_ld_sel ? shad_q.c : fl.c_in;

    if (!fl.int_ack && fl.flg_z_ld) flg_d.z = fl.flg_ld_sel ? shad_q.z : fl.z_in;

    if (fl.int_ack)    i_d = 1'b0;
    else if (fl.i_clr) i_d = 1'b0;
    else if (fl.i_set) i_d = 1'b1;

    // A fresh edge on the ack cycle wins over the clear.
    pend_d = rise_c | (pend_q & ~fl.int_ack);
  end

  assign fl.c_flag   = flg_q.c;
  assign fl.z_flag   = flg_q.z;
  assign fl.i_flag   = i_q;
  assign fl.int_pend = i_q & pend_q;
  assign fl.br_take  = br_eval(fl.br_cond, flg_q);

endmodule

// File: tb/tb_rat_flag_unit.sv
// Scoreboard bench for rat_flag_unit: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them.
module tb_rat_flag_unit;
  import rat_pkg::*;

  // Observation vector bit order: {c, z, i, pend, br, acked}
  localparam logic [5:0] MC   = 6'b100000;
  localparam logic [5:0] MZ   = 6'b010000;
  localparam logic [5:0] MI   = 6'b001000;
  localparam logic [5:0] MP   = 6'b000100;
  localparam logic [5:0] MB   = 6'b000010;
  localparam logic [5:0] MA   = 6'b000001;
  localparam logic [5:0] MALL = 6'b111111;

  typedef struct packed {
    logic [5:0] exp;
    logic [5:0] mask;
  } sb_t;

  logic clk;
  logic rst_n;
  sb_t   sb_q[$];
  string nm_q[$];
  int unsigned npass;
  int unsigned ntotal;

  rat_flag_unit_if bus();

  rat_flag_unit #(.SYNC_INTR(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fl    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_obs(input string name, input logic [5:0] exp, input logic [5:0] mask);
    sb_t e;
    e.exp  = exp;
    e.mask = mask;
    sb_q.push_back(e);
    nm_q.push_back(name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.flg_c_ld    = 1'b0;
    bus.flg_c_set   = 1'b0;
    bus.flg_c_clr   = 1'b0;
    bus.flg_z_ld    = 1'b0;
    bus.flg_shad_ld = 1'b0;
    bus.flg_ld_sel  = 1'b0;
    bus.i_set       = 1'b0;
    bus.i_clr       = 1'b0;
    bus.int_ack     = 1'b0;
  endtask

  function automatic logic exp_br(input int b, input logic c, input logic z);
    case (b)
      0:       return 1'b1;
      1:       return c;
      2:       return ~c;
      3:       return z;
      4:       return ~z;
      default: return 1'b0;
    endcase
  endfunction

  // Monitor: compare every pending expectation against the outputs at the falling edge.
  always @(negedge clk) begin
    logic [5:0] act;
    sb_t        e;
    string      nm;
    act = {bus.c_flag, bus.z_flag, bus.i_flag, bus.int_pend, bus.br_take,
           (dut.ack_q == ACK_ACKED)};
    while (sb_q.size() != 0) begin
      e  = sb_q.pop_front();
      nm = nm_q.pop_front();
      ntotal++;
      if (((act ^ e.exp) & e.mask) == 6'b0) npass++;
      else $display("FAIL %s: got %b want %b (mask %b)", nm, act, e.exp, e.mask);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1);
  end

  initial begin
    npass  = 0;
    ntotal = 0;
    {bus.c_in, bus.z_in, bus.flg_c_ld, bus.flg_c_set, bus.flg_c_clr, bus.flg_z_ld,
     bus.flg_shad_ld, bus.flg_ld_sel, bus.i_set, bus.i_clr, bus.intr, bus.int_ack} = '0;
    bus.br_cond = 3'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    expect_obs("reset", 6'b000010, MALL);

    // Carry chain and C priority
    bus.c_in = 1'b1; bus.flg_c_ld = 1'b1; tick(); bus.c_in = 1'b0;
    expect_obs("c_ld", 6'b100000, MC);
    bus.br_cond = 3'd1;
    expect_obs("brcs_c1", 6'b000010, MB);
    tick(); bus.br_cond = 3'd0;
    bus.flg_c_set = 1'b1; bus.flg_c_clr = 1'b1; tick();
    expect_obs("set_clr", 6'b000000, MC);
    bus.flg_c_set = 1'b1; bus.flg_c_ld = 1'b1; tick();
    expect_obs("set_over_ld", 6'b100000, MC);
    bus.flg_c_clr = 1'b1; tick();
    expect_obs("clr", 6'b000000, MC);
    bus.z_in = 1'b1; bus.flg_z_ld = 1'b1; tick(); bus.z_in = 1'b0;
    expect_obs("z_ld1", 6'b010000, MZ);
    bus.flg_z_ld = 1'b1; tick();
    expect_obs("z_ld0", 6'b000000, MZ);

    // Asynchronous reset mid-cycle with C, I and pending all set
    bus.flg_c_set = 1'b1; bus.i_set = 1'b1; tick();
    bus.intr = 1'b1; tick(); tick(); tick(); bus.intr = 1'b0;
    expect_obs("t1_pend", 6'b101100, MC | MI | MP);
    @(posedge clk); #2 rst_n = 1'b0;
    expect_obs("t1_async", 6'b000010, MALL);
    @(posedge clk); #1 rst_n = 1'b1;
    expect_obs("t1_release", 6'b000010, MALL);

    // Save on ack, ALU overwrite, restore
    bus.flg_c_set = 1'b1; bus.i_set = 1'b1; tick();
    expect_obs("t3_pre", 6'b101000, MC | MZ | MI | MA);
    bus.int_ack = 1'b1; bus.i_set = 1'b1; tick();
    expect_obs("t3_ack", 6'b100001, MC | MZ | MI | MA);
    bus.c_in = 1'b0; bus.z_in = 1'b1; bus.flg_c_ld = 1'b1; bus.flg_z_ld = 1'b1; tick();
    bus.z_in = 1'b0;
    expect_obs("t3_alu", 6'b010001, MC | MZ | MA);
    bus.flg_ld_sel = 1'b1; bus.flg_c_ld = 1'b1; bus.flg_z_ld = 1'b1; tick();
    expect_obs("t3_restore", 6'b100000, MC | MZ | MA);

    // Pending request retained while I=0, surfaces on SEI, cleared by ack
    bus.intr = 1'b1; tick(); bus.intr = 1'b0; tick(); tick(); tick();
    expect_obs("t4_masked", 6'b000000, MI | MP);
    bus.i_set = 1'b1; tick();
    expect_obs("t4_surface", 6'b001100, MI | MP);
    bus.int_ack = 1'b1; tick();
    expect_obs("t4_ack", 6'b000001, MI | MP | MA);
    bus.flg_ld_sel = 1'b1; bus.flg_z_ld = 1'b1; tick();
    expect_obs("t4_restore", 6'b100000, MC | MZ | MA);

    // Synchronizer latency: pending appears on the third edge after INTR rises
    bus.i_set = 1'b1; tick(); tick();
    bus.intr = 1'b1; tick();
    expect_obs("t4_lat1", 6'b000000, MP);
    tick();
    expect_obs("t4_lat2", 6'b000000, MP);
    tick();
    expect_obs("t4_lat3", 6'b000100, MP);
    bus.intr = 1'b0;
    bus.int_ack = 1'b1; tick();
    expect_obs("t4_ack2", 6'b000001, MI | MP | MA);
    bus.flg_ld_sel = 1'b1; bus.flg_z_ld = 1'b1; tick();
    expect_obs("t4_restore2", 6'b000000, MA);

    // Branch table sweep
    for (int cz = 0; cz < 4; cz++) begin
      logic c, z;
      c = cz[1];
      z = cz[0];
      if (c) bus.flg_c_set = 1'b1;
      else   bus.flg_c_clr = 1'b1;
      bus.z_in = z; bus.flg_z_ld = 1'b1; tick(); bus.z_in = 1'b0;
      for (int b = 0; b < 8; b++) begin
        bus.br_cond = 3'(b);
        expect_obs($sformatf("br_c%0d_z%0d_b%0d", c, z, b),
                   {4'b0, exp_br(b, c, z), 1'b0}, MB);
        tick();
      end
    end
    bus.br_cond = 3'd0;

    // Nested ack keeps the first saved context
    bus.flg_c_set = 1'b1; tick();
    bus.int_ack = 1'b1; tick();
    expect_obs("t6_ack1", 6'b100001, MC | MA);
    bus.c_in = 1'b0; bus.flg_c_ld = 1'b1; tick();
    expect_obs("t6_ld", 6'b000001, MC | MA);
    bus.int_ack = 1'b1; tick();
    expect_obs("t6_ack2", 6'b000001, MC | MI | MA);
    bus.flg_ld_sel = 1'b1; bus.flg_c_ld = 1'b1; tick();
    expect_obs("t6_restore", 6'b100000, MC | MA);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      $display("FAIL scoreboard: %0d expectations never checked, want 0", sb_q.size());
      ntotal += sb_q.size();
    end
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
